// File: rtl/result_channel_buffer_if.sv
// Handshake bundle between one channel's compute pipeline, its staging buffer
// and the result collector. The buffer sits on the slave side.
interface result_channel_buffer_if #(
    parameter int DATA_W = 16
);
    logic              wr_vld;
    logic [DATA_W-1:0] wr_data;
    logic              wr_rdy;
    logic              wr_drop;
    logic              buf_ready;
    logic              rd_sop;
    logic              rd_vld;
    logic [DATA_W-1:0] rd_data;
    logic              rd_eop;
    logic              rd_underflow;

    modport master (
        output wr_vld, wr_data, rd_sop,
        input  wr_rdy, wr_drop, buf_ready, rd_vld, rd_data, rd_eop, rd_underflow
    );

    modport slave (
        input  wr_vld, wr_data, rd_sop,
        output wr_rdy, wr_drop, buf_ready, rd_vld, rd_data, rd_eop, rd_underflow
    );
endinterface

// File: rtl/result_channel_buffer.sv
// Per-channel staging buffer: gathers DEPTH result words, then replays them as a
// contiguous burst on rd_sop, always closing with rd_eop so the chain advances.
module result_channel_buffer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    result_channel_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] WR_LAST = CW'(DEPTH - 1);
    localparam logic [AW-1:0] RD_LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, FILL, READY, DRAIN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [CW-1:0]     wr_cnt;
    logic [AW-1:0]     rd_cnt;

    logic wr_rdy;
    logic buf_ready;
    logic wr_en;
    logic drop;
    logic burst_start;
    logic burst_end;
    logic underflow;

    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;
    logic              eop_p1;
    logic              uflow_p1;
    logic              drop_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Handshake outputs depend on state alone, so no input reaches them combinationally.
    always_comb begin
        state_nxt   = state;
        wr_rdy      = 1'b0;
        buf_ready   = 1'b0;
        wr_en       = 1'b0;
        burst_start = 1'b0;
        burst_end   = 1'b0;
        underflow   = 1'b0;
        case (state)
            IDLE: begin
                wr_rdy    = 1'b1;
                wr_en     = bus.wr_vld;
                underflow = bus.rd_sop;
                if (bus.wr_vld) state_nxt = FILL;
            end
            FILL: begin
                wr_rdy    = 1'b1;
                wr_en     = bus.wr_vld;
                underflow = bus.rd_sop;
                if (bus.wr_vld && wr_cnt == WR_LAST) state_nxt = READY;
            end
            READY: begin
                buf_ready   = 1'b1;
                burst_start = bus.rd_sop;
                if (bus.rd_sop) state_nxt = DRAIN;
            end
            DRAIN: begin
                // The eop beat is already on the outputs; this edge closes the burst.
                burst_end = eop_p1;
                if (eop_p1) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign drop = bus.wr_vld & ~wr_rdy;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_cnt[AW-1:0]] <= bus.wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (wr_en)          wr_cnt <= wr_cnt + CW'(1);
            else if (burst_end) wr_cnt <= '0;
            // rd_cnt points at the word for the next beat; it wraps to 0 on the eop beat.
            if (burst_start)                  rd_cnt <= AW'(1);
            else if (state == DRAIN && !eop_p1) rd_cnt <= rd_cnt + AW'(1);
        end
    end

    // Output stage p1: registered burst beats and one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            data_p1  <= '0;
            eop_p1   <= 1'b0;
            uflow_p1 <= 1'b0;
            drop_p1  <= 1'b0;
        end else begin
            vld_p1   <= 1'b0;
            data_p1  <= '0;
            eop_p1   <= 1'b0;
            uflow_p1 <= underflow;
            drop_p1  <= drop;
            if (burst_start) begin
                vld_p1  <= 1'b1;
                data_p1 <= mem[0];
            end else if (state == DRAIN && !eop_p1) begin
                vld_p1  <= 1'b1;
                data_p1 <= mem[rd_cnt];
                eop_p1  <= (rd_cnt == RD_LAST);
            end else if (underflow) begin
                eop_p1 <= 1'b1;
            end
        end
    end

    assign bus.wr_rdy       = wr_rdy;
    assign bus.buf_ready    = buf_ready;
    assign bus.wr_drop      = drop_p1;
    assign bus.rd_vld       = vld_p1;
    assign bus.rd_data      = data_p1;
    assign bus.rd_eop       = eop_p1;
    assign bus.rd_underflow = uflow_p1;
endmodule

// File: tb/tb_result_channel_buffer.sv
// Scoreboard bench for result_channel_buffer: two instances (A, and B chained off A's rd_eop).
module tb_result_channel_buffer;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic chain_en = 1'b0;

    always #5 clk = ~clk;

    result_channel_buffer_if #(.DATA_W(DATA_W)) a_if ();
    result_channel_buffer_if #(.DATA_W(DATA_W)) b_if ();

    result_channel_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(a_if.slave)
    );
    result_channel_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(b_if.slave)
    );

    assign b_if.rd_sop = a_if.rd_eop & chain_en;

    typedef struct packed {
        logic              vld;
        logic [DATA_W-1:0] data;
        logic              eop;
        logic              uflow;
        logic              drop;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ex_a;
    exp_t ex_b;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic cmp_out(input string tag, input logic v, input logic [DATA_W-1:0] d,
                           input logic e, input logic u, input logic dr, input exp_t x);
        check({tag, "_vld"},   32'(v),  32'(x.vld));
        check({tag, "_data"},  32'(d),  32'(x.data));
        check({tag, "_eop"},   32'(e),  32'(x.eop));
        check({tag, "_uflow"}, 32'(u),  32'(x.uflow));
        check({tag, "_drop"},  32'(dr), 32'(x.drop));
    endtask

    task automatic push_exp(input bit to_b, input logic v, input logic [DATA_W-1:0] d,
                            input logic e, input logic u, input logic dr);
        exp_t x;
        x.vld = v; x.data = d; x.eop = e; x.uflow = u; x.drop = dr;
        if (to_b) qb.push_back(x);
        else      qa.push_back(x);
    endtask

    task automatic push_burst(input bit to_b, input logic [DATA_W-1:0] base);
        for (int i = 0; i < DEPTH; i++)
            push_exp(to_b, 1'b1, base + DATA_W'(i), (i == DEPTH - 1), 1'b0, 1'b0);
    endtask

    // Monitors: any output activity pops the next expected event; quiet cycles must show zero data.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_if.rd_vld | a_if.rd_eop | a_if.rd_underflow | a_if.wr_drop) begin
                if (qa.size() == 0) check("a_unexpected_out", 32'(qa.size()), 32'd1);
                else begin
                    ex_a = qa.pop_front();
                    cmp_out("a", a_if.rd_vld, a_if.rd_data, a_if.rd_eop, a_if.rd_underflow, a_if.wr_drop, ex_a);
                end
            end else check("a_quiet_data", 32'(a_if.rd_data), 32'd0);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (b_if.rd_vld | b_if.rd_eop | b_if.rd_underflow | b_if.wr_drop) begin
                if (qb.size() == 0) check("b_unexpected_out", 32'(qb.size()), 32'd1);
                else begin
                    ex_b = qb.pop_front();
                    cmp_out("b", b_if.rd_vld, b_if.rd_data, b_if.rd_eop, b_if.rd_underflow, b_if.wr_drop, ex_b);
                end
            end else check("b_quiet_data", 32'(b_if.rd_data), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_a(input logic [DATA_W-1:0] d);
        a_if.wr_vld  = 1'b1;
        a_if.wr_data = d;
        tick();
        a_if.wr_vld  = 1'b0;
    endtask

    task automatic fill_a(input logic [DATA_W-1:0] base, input int first, input int count);
        for (int i = first; i < first + count; i++) write_a(base + DATA_W'(i));
    endtask

    task automatic sop_a();
        a_if.rd_sop = 1'b1;
        tick();
        a_if.rd_sop = 1'b0;
    endtask

    // Full burst from READY with cycle-exact checks on first beat, eop beat and release.
    task automatic burst_a(input string tag, input logic [DATA_W-1:0] base);
        push_burst(1'b0, base);
        sop_a();
        check({tag, "_first_vld"}, 32'(a_if.rd_vld), 32'd1);
        check({tag, "_ready_low"}, 32'(a_if.buf_ready), 32'd0);
        repeat (DEPTH - 1) tick();
        check({tag, "_eop_cycle"}, 32'(a_if.rd_eop), 32'd1);
        check({tag, "_rdy_during"}, 32'(a_if.wr_rdy), 32'd0);
        tick();
        check({tag, "_rdy_after"}, 32'(a_if.wr_rdy), 32'd1);
        check({tag, "_vld_after"}, 32'(a_if.rd_vld), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_rdy"},    32'(a_if.wr_rdy),       32'd1);
        check({tag, "_buf_ready"}, 32'(a_if.buf_ready),    32'd0);
        check({tag, "_rd_vld"},    32'(a_if.rd_vld),       32'd0);
        check({tag, "_rd_data"},   32'(a_if.rd_data),      32'd0);
        check({tag, "_rd_eop"},    32'(a_if.rd_eop),       32'd0);
        check({tag, "_wr_drop"},   32'(a_if.wr_drop),      32'd0);
        check({tag, "_uflow"},     32'(a_if.rd_underflow), 32'd0);
    endtask

    int beats, first_cyc, last_cyc, overlap;

    initial begin
        a_if.wr_vld = 1'b0; a_if.wr_data = '0; a_if.rd_sop = 1'b0;
        b_if.wr_vld = 1'b0; b_if.wr_data = '0;
        repeat (2) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Fill and drain
        fill_a(16'h1000, 0, DEPTH - 1);
        check("fill7_buf_ready", 32'(a_if.buf_ready), 32'd0);
        check("fill7_wr_rdy", 32'(a_if.wr_rdy), 32'd1);
        write_a(16'h1007);
        check("fill8_buf_ready", 32'(a_if.buf_ready), 32'd1);
        check("fill8_wr_rdy", 32'(a_if.wr_rdy), 32'd0);
        burst_a("t1", 16'h1000);

        // Underflow after 3 words, then complete and drain intact
        fill_a(16'h2000, 0, 3);
        push_exp(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        sop_a();
        check("uf_eop", 32'(a_if.rd_eop), 32'd1);
        check("uf_flag", 32'(a_if.rd_underflow), 32'd1);
        check("uf_vld", 32'(a_if.rd_vld), 32'd0);
        check("uf_wr_rdy", 32'(a_if.wr_rdy), 32'd1);
        tick();
        check("uf_pulse_end", 32'(a_if.rd_underflow), 32'd0);
        fill_a(16'h2000, 3, DEPTH - 3);
        check("uf_refill_ready", 32'(a_if.buf_ready), 32'd1);
        burst_a("t2", 16'h2000);

        // Overflow drop in READY
        fill_a(16'h3000, 0, DEPTH);
        push_exp(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        write_a(16'hDEAD);
        check("drop_pulse", 32'(a_if.wr_drop), 32'd1);
        check("drop_still_ready", 32'(a_if.buf_ready), 32'd1);
        tick();
        check("drop_pulse_end", 32'(a_if.wr_drop), 32'd0);
        burst_a("t3", 16'h3000);

        // Eighth write and rd_sop together: underflow, but the write lands
        fill_a(16'h4000, 0, DEPTH - 1);
        push_exp(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        a_if.wr_vld = 1'b1; a_if.wr_data = 16'h4007; a_if.rd_sop = 1'b1;
        tick();
        a_if.wr_vld = 1'b0; a_if.rd_sop = 1'b0;
        check("sim_uflow", 32'(a_if.rd_underflow), 32'd1);
        check("sim_eop", 32'(a_if.rd_eop), 32'd1);
        check("sim_buf_ready", 32'(a_if.buf_ready), 32'd1);
        burst_a("t4", 16'h4000);

        // Two-instance chain: A's eop starts B
        for (int i = 0; i < DEPTH; i++) begin
            a_if.wr_vld = 1'b1; a_if.wr_data = 16'h00A0 + 16'(i);
            b_if.wr_vld = 1'b1; b_if.wr_data = 16'h00B0 + 16'(i);
            tick();
        end
        a_if.wr_vld = 1'b0; b_if.wr_vld = 1'b0;
        check("chain_b_ready", 32'(b_if.buf_ready), 32'd1);
        chain_en = 1'b1;
        push_burst(1'b0, 16'h00A0);
        push_burst(1'b1, 16'h00B0);
        beats = 0; first_cyc = -1; last_cyc = -1; overlap = 0;
        sop_a();
        for (int k = 0; k < 2 * DEPTH + 4; k++) begin
            if (a_if.rd_vld && b_if.rd_vld) overlap++;
            if (a_if.rd_vld || b_if.rd_vld) begin
                beats++;
                if (first_cyc < 0) first_cyc = k;
                last_cyc = k;
            end
            tick();
        end
        chain_en = 1'b0;
        check("chain_beats", 32'(beats), 32'(2 * DEPTH));
        check("chain_first", 32'(first_cyc), 32'd0);
        check("chain_span", 32'(last_cyc - first_cyc + 1), 32'(2 * DEPTH));
        check("chain_overlap", 32'(overlap), 32'd0);

        // Reset mid-burst at beat 4
        fill_a(16'h6000, 0, DEPTH);
        for (int i = 0; i < 4; i++) push_exp(1'b0, 1'b1, 16'h6000 + 16'(i), 1'b0, 1'b0, 1'b0);
        sop_a();
        repeat (3) tick();
        check("rst_beat4_data", 32'(a_if.rd_data), 32'h6003);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_wr_rdy", 32'(a_if.wr_rdy), 32'd1);
        check("post_rst_buf_ready", 32'(a_if.buf_ready), 32'd0);
        push_exp(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        sop_a();
        check("post_rst_uflow", 32'(a_if.rd_underflow), 32'd1);
        check("post_rst_eop", 32'(a_if.rd_eop), 32'd1);

        repeat (3) tick();
        check("qa_drained", 32'(qa.size()), 32'd0);
        check("qb_drained", 32'(qb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
